instr_imm_encoder: RTL and testbench

INSTR_IMM_ENCODER -- requirements
Module: instr_imm_encoder

---
 rtl/ppu_enc_pkg.sv | 48 ++++
 rtl/imm_packer.sv | 48 ++++
 rtl/instr_imm_encoder.sv | 105 ++++++++++
 tb/tb_instr_imm_encoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_enc_pkg.sv
// Shared types and constants for the RISC-V instruction immediate encoder.
// Holds the format enum, base opcode constants, the S1 request record and a
// small sign-extension helper that the optional range check uses.
package ppu_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_OP     = 7'h33;

  // The format is kept as raw bits so that the illegal codes 6 and 7 survive
  // into the packer, which treats them as R with an error flag.
  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } encReq_t;

  // True when every bit from lsb up to 31 equals the sign bit, i.e. the value
  // survives truncation to an (lsb+1)-bit signed field unchanged.
  function automatic logic signExtOk(input logic [31:0] value, input int unsigned lsb);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if ((i >= int'(lsb)) && (value[i] != value[31])) begin
        ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/imm_packer.sv
// Combinational packer between S1 and S2: scatters register fields and
// immediate bits into a 32-bit RISC-V word according to the format.
// Optional macro IMM_RANGE_CHECK_EN compiles in the immediate range check;
// without it err_o is tied low and no check logic exists.
module imm_packer
  import ppu_enc_pkg::*;
(
  input  encReq_t     req_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  // Field placement per format; illegal formats fall back to R layout.
  always_comb begin
    instr_o = '0;
    case (fmt_e'(req_i.fmt))
      FMT_I: instr_o = {req_i.imm[11:0], req_i.rs1, req_i.funct3, req_i.rd, req_i.opcode};
      FMT_S: instr_o = {req_i.imm[11:5], req_i.rs2, req_i.rs1, req_i.funct3,
                        req_i.imm[4:0], req_i.opcode};
      FMT_B: instr_o = {req_i.imm[12], req_i.imm[10:5], req_i.rs2, req_i.rs1, req_i.funct3,
                        req_i.imm[4:1], req_i.imm[11], req_i.opcode};
      FMT_U: instr_o = {req_i.imm[31:12], req_i.rd, req_i.opcode};
      FMT_J: instr_o = {req_i.imm[20], req_i.imm[10:1], req_i.imm[11], req_i.imm[19:12],
                        req_i.rd, req_i.opcode};
      default: instr_o = {req_i.funct7, req_i.rs2, req_i.rs1, req_i.funct3, req_i.rd,
                          req_i.opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Flag immediates that the chosen format cannot represent exactly.
  always_comb begin
    err_o = 1'b0;
    case (fmt_e'(req_i.fmt))
      FMT_R: err_o = 1'b0;
      FMT_I: err_o = !signExtOk(req_i.imm, 11);
      FMT_S: err_o = !signExtOk(req_i.imm, 11);
      FMT_B: err_o = !signExtOk(req_i.imm, 12) || req_i.imm[0];
      FMT_U: err_o = (req_i.imm[11:0] != 12'd0);
      FMT_J: err_o = !signExtOk(req_i.imm, 20) || req_i.imm[0];
      default: err_o = 1'b1;
    endcase
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/instr_imm_encoder.sv
// Two-stage RISC-V instruction encoder: S1 registers the request fields,
// imm_packer builds the word, S2 registers it for a valid/ready output.
// Optional macro IMM_RANGE_CHECK_EN enables immediate range checking.
module instr_imm_encoder
  import ppu_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic [15:0] enc_count
);

  logic        s1Valid_q, s1Valid_d;
  encReq_t     s1Req_q, s1Req_d;
  logic        outValid_q, outValid_d;
  logic [31:0] outInstr_q, outInstr_d;
  logic        outErr_q, outErr_d;
  logic [15:0] encCount_q, encCount_d;

  logic        s2Free;
  logic        s1Advance;
  logic        inFire;
  logic [31:0] packedInstr;
  logic        packedErr;

  imm_packer uPacker (
    .req_i   (s1Req_q),
    .instr_o (packedInstr),
    .err_o   (packedErr)
  );

  // Handshake and next-state: S2 frees when empty or draining, S1 follows S2.
  always_comb begin
    s2Free     = !outValid_q || out_ready;
    s1Advance  = s1Valid_q && s2Free;
    in_ready   = !s1Valid_q || s2Free;
    inFire     = in_valid && in_ready;

    s1Valid_d  = s1Valid_q;
    s1Req_d    = s1Req_q;
    outValid_d = outValid_q;
    outInstr_d = outInstr_q;
    outErr_d   = outErr_q;
    encCount_d = encCount_q;

    if (s1Advance) begin
      s1Valid_d = 1'b0;
    end
    if (inFire) begin
      s1Valid_d = 1'b1;
      s1Req_d   = '{fmt: fmt, opcode: opcode, rd: rd, rs1: rs1, rs2: rs2,
                    funct3: funct3, funct7: funct7, imm: imm};
    end

    if (s2Free) begin
      outValid_d = s1Valid_q;
    end
    if (s1Advance) begin
      outInstr_d = packedInstr;
      outErr_d   = packedErr;
    end

    if (outValid_q && out_ready) begin
      encCount_d = encCount_q + 16'd1;
    end
  end

  // Pipeline and counter registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q  <= 1'b0;
      s1Req_q    <= '0;
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outErr_q   <= 1'b0;
      encCount_q <= '0;
    end else begin
      s1Valid_q  <= s1Valid_d;
      s1Req_q    <= s1Req_d;
      outValid_q <= outValid_d;
      outInstr_q <= outInstr_d;
      outErr_q   <= outErr_d;
      encCount_q <= encCount_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_instr = outInstr_q;
  assign out_err   = outErr_q;
  assign enc_count = encCount_q;

endmodule

// File: tb/tb_instr_imm_encoder.sv
// Self-checking bench for instr_imm_encoder: table of hand-encoded vectors,
// then stall, mid-operation reset and counter wrap sequences.
module tb_instr_imm_encoder;

`ifdef IMM_RANGE_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] enc_count;

  typedef struct packed {
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [31:0] expInstr;
    logic        errChk;
  } vec_t;

  localparam int NUM_VECS = 16;
  vec_t vecs [NUM_VECS];

  int testCount = 0;
  int failCount = 0;

  instr_imm_encoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fmt       (fmt),
    .opcode    (opcode),
    .rd        (rd),
    .rs1       (rs1),
    .rs2       (rs2),
    .funct3    (funct3),
    .funct7    (funct7),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .enc_count (enc_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic valid, input vec_t v);
    in_valid = valid;
    fmt      = v.fmt;
    opcode   = v.opcode;
    rd       = v.rd;
    rs1      = v.rs1;
    rs2      = v.rs2;
    funct3   = v.funct3;
    funct7   = v.funct7;
    imm      = v.imm;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Simple I-type requests used by the sequences: addi xN, x0, 0.
  function automatic vec_t seqReq(input int n);
    vec_t v;
    v = '{3'd1, 7'h13, 5'(n + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,
          32'h13 | (32'(n + 1) << 7), 1'b0};
    return v;
  endfunction

  initial begin
    vec_t v;
    int   idx;
    int   got;
    int   xfers;
    logic acc;

    vecs[0]  = '{3'd1, 7'h13, 5'd5,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFFFFFF, 32'hFFF00293, 1'b0};
    vecs[1]  = '{3'd3, 7'h63, 5'd31, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0};
    vecs[2]  = '{3'd5, 7'h6F, 5'd1,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h00000008, 32'h008000EF, 1'b0};
    vecs[3]  = '{3'd5, 7'h6F, 5'd1,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00000003, 32'h002000EF, 1'b1};
    vecs[4]  = '{3'd0, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'hFFFFFFFF, 32'h402081B3, 1'b0};
    vecs[5]  = '{3'd2, 7'h23, 5'd31, 5'd1,  5'd2,  3'd2, 7'h7F, 32'h00000008, 32'h0020A423, 1'b0};
    vecs[6]  = '{3'd4, 7'h37, 5'd5,  5'd31, 5'd31, 3'd7, 7'h7F, 32'h12345000, 32'h123452B7, 1'b0};
    vecs[7]  = '{3'd4, 7'h37, 5'd5,  5'd0,  5'd0,  3'd0, 7'h00, 32'h12345001, 32'h123452B7, 1'b1};
    vecs[8]  = '{3'd1, 7'h13, 5'd1,  5'd2,  5'd0,  3'd0, 7'h00, 32'h00000800, 32'h80010093, 1'b1};
    vecs[9]  = '{3'd1, 7'h13, 5'd1,  5'd2,  5'd0,  3'd0, 7'h00, 32'hFFFFF800, 32'h80010093, 1'b0};
    vecs[10] = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, 32'h00000FFE, 32'h7E001FE3, 1'b0};
    vecs[11] = '{3'd3, 7'h63, 5'd0,  5'd0,  5'd0,  3'd1, 7'h00, 32'h00001000, 32'h80001063, 1'b1};
    vecs[12] = '{3'd6, 7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h20, 32'h00000000, 32'h402081B3, 1'b1};
    vecs[13] = '{3'd5, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFE, 32'hFFFFF06F, 1'b0};
    vecs[14] = '{3'd5, 7'h6F, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'h00100000, 32'h8000006F, 1'b1};
    vecs[15] = '{3'd2, 7'h23, 5'd0,  5'd0,  5'd0,  3'd0, 7'h00, 32'hFFFFFFFF, 32'hFE000FA3, 1'b0};

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, vecs[0]);

    // Reset state.
    @(negedge clk);
    #1;
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset out_instr", out_instr, 32'd0);
    checkOutput("reset out_err",   32'(out_err), 32'd0);
    checkOutput("reset enc_count", 32'(enc_count), 32'd0);
    checkOutput("reset in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of single requests, each observed two edges after acceptance.
    for (int i = 0; i < NUM_VECS; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("vec%0d out_instr", i), out_instr, vecs[i].expInstr);
      checkOutput($sformatf("vec%0d out_err", i), 32'(out_err),
                  32'(vecs[i].errChk & CHK_EN));
    end
    @(negedge clk);
    checkOutput("table drained", 32'(out_valid), 32'd0);
    checkOutput("table enc_count", 32'(enc_count), 32'(NUM_VECS));

    // Back-pressure: three requests against a stalled output.
    doReset();
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        checkOutput($sformatf("stall%0d out_valid", c), 32'(out_valid), 32'd1);
        checkOutput($sformatf("stall%0d out_instr", c), out_instr, seqReq(0).expInstr);
      end
      v = seqReq(idx);
      applyStimulus(idx < 3, v);
      out_ready = 1'b0;
      #1;
      acc = in_valid && in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    #1;
    checkOutput("stall accepted", 32'(idx), 32'd2);
    checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    got = 0;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      v = seqReq(idx);
      applyStimulus(idx < 3, v);
      out_ready = 1'b1;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        checkOutput($sformatf("drain%0d out_instr", got), out_instr,
                    seqReq(got).expInstr);
        got++;
      end
      @(posedge clk);
      if (acc) idx++;
      if (got == 3) break;
    end
    checkOutput("drain count", 32'(got), 32'd3);
    @(negedge clk);
    checkOutput("drain enc_count", 32'(enc_count), 32'd3);
    checkOutput("drain no duplicate", 32'(out_valid), 32'd0);

    // Reset while both stages are full.
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      v = seqReq(c);
      applyStimulus(1'b1, v);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("full before reset", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async out_valid", 32'(out_valid), 32'd0);
    checkOutput("async enc_count", 32'(enc_count), 32'd0);
    checkOutput("async out_instr", out_instr, 32'd0);
    checkOutput("async in_ready",  32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post reset%0d out_valid", c), 32'(out_valid), 32'd0);
    end

    // Counter wrap: 0x10001 back-to-back transfers from reset.
    doReset();
    v = seqReq(0);
    applyStimulus(1'b1, v);
    out_ready = 1'b1;
    xfers = 0;
    for (int c = 0; c < 70000; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (xfers == 32'hFFFF) begin
          checkOutput("count at 0xFFFF", 32'(enc_count), 32'hFFFF);
        end
        if (xfers == 32'h10000) begin
          checkOutput("count wrapped", 32'(enc_count), 32'h0);
        end
        xfers++;
      end
      if (xfers == 32'h10001) break;
    end
    checkOutput("wrap transfers", 32'(xfers), 32'h10001);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("wrap enc_count", 32'(enc_count), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
